// File: rtl/pb_pulser_pkg.sv
// Shared definitions for the multi-channel push-button pulser:
// channel FSM state encoding and the counter width helper.
package pb_pulser_pkg;

  // State encodings kept as plain constants so older code can match on them.
  localparam logic [1:0] ST_IDLE     = 2'd0;
  localparam logic [1:0] ST_DB_PRESS = 2'd1;
  localparam logic [1:0] ST_HELD     = 2'd2;
  localparam logic [1:0] ST_DB_REL   = 2'd3;

  typedef enum logic [1:0] {
    IDLE     = ST_IDLE,
    DB_PRESS = ST_DB_PRESS,
    HELD     = ST_HELD,
    DB_REL   = ST_DB_REL
  } pb_state_t;

  // Bits needed to hold values 0..max_val (at least one bit).
  function automatic int cnt_width(input int max_val);
    if (max_val < 2) begin
      return 1;
    end else begin
      return $clog2(max_val + 1);
    end
  endfunction

endpackage

// File: rtl/pb_pulser_chan.sv
// One push-button channel: synchroniser, press/release debounce FSM,
// auto-repeat counter and registered strobe/level outputs.
module pb_pulser_chan
  import pb_pulser_pkg::*;
#(
  parameter int SYNC_STAGES   = 2,
  parameter int DEBOUNCE_CYC  = 50000,
  parameter int REPEAT_EN     = 1,
  parameter int REPEAT_DELAY  = 25000000,
  parameter int REPEAT_PERIOD = 5000000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic pulse,
  output logic rel_pulse,
  output logic level
);

  localparam int REP_MAX = ((REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD) - 1;
  localparam int DW      = cnt_width(DEBOUNCE_CYC - 1);
  localparam int RW      = cnt_width(REP_MAX);

  localparam logic [DW-1:0] DB_LAST     = DW'(DEBOUNCE_CYC - 1);
  localparam logic [DW-1:0] DB_ONE      = DW'(1);
  localparam logic [DW-1:0] DB_ZERO     = DW'(0);
  localparam logic [RW-1:0] DELAY_LAST  = RW'(REPEAT_DELAY - 1);
  localparam logic [RW-1:0] PERIOD_LAST = RW'(REPEAT_PERIOD - 1);
  localparam logic [RW-1:0] REP_ONE     = RW'(1);
  localparam logic [RW-1:0] REP_ZERO    = RW'(0);

  logic [SYNC_STAGES-1:0] sync_r;
  logic                   s_s;

  pb_state_t     state_r, state_s;
  logic [DW-1:0] db_cnt_r, db_cnt_s;
  logic [RW-1:0] rep_cnt_r, rep_cnt_s;
  logic [RW-1:0] rep_last_s;
  logic          rep_phase_r, rep_phase_s;  // 0: waiting first repeat, 1: periodic
  logic          pulse_s, rel_s, level_s;

  assign s_s = sync_r[SYNC_STAGES-1];

  // Shift the raw asynchronous button level through the synchroniser chain.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_r <= '0;
    end else begin
      sync_r <= {sync_r[SYNC_STAGES-2:0], btn};
    end
  end

  // Next-state, counter and strobe decode for the debounce/repeat FSM.
  always_comb begin
    state_s     = state_r;
    db_cnt_s    = db_cnt_r;
    rep_cnt_s   = rep_cnt_r;
    rep_phase_s = rep_phase_r;
    pulse_s     = 1'b0;
    rel_s       = 1'b0;
    level_s     = level;
    rep_last_s  = rep_phase_r ? PERIOD_LAST : DELAY_LAST;

    case (state_r)
      IDLE: begin
        level_s = 1'b0;
        if (s_s) begin
          state_s  = DB_PRESS;
          db_cnt_s = DB_ZERO;
        end else begin
          state_s = IDLE;
        end
      end

      DB_PRESS: begin
        level_s = 1'b0;
        if (!s_s) begin
          state_s = IDLE;
        end else if (db_cnt_r == DB_LAST) begin
          state_s     = HELD;
          pulse_s     = 1'b1;
          level_s     = 1'b1;
          rep_cnt_s   = REP_ZERO;
          rep_phase_s = 1'b0;
        end else begin
          db_cnt_s = db_cnt_r + DB_ONE;
        end
      end

      HELD: begin
        level_s = 1'b1;
        // The repeat counter counts every cycle spent in HELD. A repeat that
        // falls due while the button is dropping is held until HELD resumes.
        if (REPEAT_EN != 0) begin
          if (rep_cnt_r == rep_last_s) begin
            if (s_s) begin
              pulse_s     = 1'b1;
              rep_cnt_s   = REP_ZERO;
              rep_phase_s = 1'b1;
            end else begin
              rep_cnt_s = rep_cnt_r;
            end
          end else begin
            rep_cnt_s = rep_cnt_r + REP_ONE;
          end
        end else begin
          rep_cnt_s = rep_cnt_r;
        end
        if (!s_s) begin
          state_s  = DB_REL;
          db_cnt_s = DB_ZERO;
        end else begin
          state_s = HELD;
        end
      end

      DB_REL: begin
        level_s = 1'b1;
        if (s_s) begin
          state_s = HELD;
        end else if (db_cnt_r == DB_LAST) begin
          state_s = IDLE;
          rel_s   = 1'b1;
          level_s = 1'b0;
        end else begin
          db_cnt_s = db_cnt_r + DB_ONE;
        end
      end

      default: begin
        state_s = IDLE;
        level_s = 1'b0;
      end
    endcase
  end

  // Register FSM state, counters and all outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= IDLE;
      db_cnt_r    <= DB_ZERO;
      rep_cnt_r   <= REP_ZERO;
      rep_phase_r <= 1'b0;
      pulse       <= 1'b0;
      rel_pulse   <= 1'b0;
      level       <= 1'b0;
    end else begin
      state_r     <= state_s;
      db_cnt_r    <= db_cnt_s;
      rep_cnt_r   <= rep_cnt_s;
      rep_phase_r <= rep_phase_s;
      pulse       <= pulse_s;
      rel_pulse   <= rel_s;
      level       <= level_s;
    end
  end

endmodule

// File: rtl/pb_pulser_multi.sv
// Multi-channel push-button conditioner: one independent channel per button.
module pb_pulser_multi
  import pb_pulser_pkg::*;
#(
  parameter int CHANNELS      = 4,
  parameter int SYNC_STAGES   = 2,
  parameter int DEBOUNCE_CYC  = 50000,
  parameter int REPEAT_EN     = 1,
  parameter int REPEAT_DELAY  = 25000000,
  parameter int REPEAT_PERIOD = 5000000
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [CHANNELS-1:0] btn_in,
  output logic [CHANNELS-1:0] pulse,
  output logic [CHANNELS-1:0] rel_pulse,
  output logic [CHANNELS-1:0] level
);

  for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
    pb_pulser_chan #(
      .SYNC_STAGES   (SYNC_STAGES),
      .DEBOUNCE_CYC  (DEBOUNCE_CYC),
      .REPEAT_EN     (REPEAT_EN),
      .REPEAT_DELAY  (REPEAT_DELAY),
      .REPEAT_PERIOD (REPEAT_PERIOD)
    ) u_chan (
      .clk       (clk),
      .rst       (rst),
      .btn       (btn_in[i]),
      .pulse     (pulse[i]),
      .rel_pulse (rel_pulse[i]),
      .level     (level[i])
    );
  end

endmodule

// File: tb/tb_pb_pulser_multi.sv
// Directed bench for pb_pulser_multi with DEBOUNCE_CYC=4, SYNC_STAGES=2,
// REPEAT_DELAY=10, REPEAT_PERIOD=3; a second instance has repeat disabled.
module tb_pb_pulser_multi;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] btn;
  logic [3:0] pulse, rel_pulse, level;
  logic [3:0] pulse_n, rel_pulse_n, level_n;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  pb_pulser_multi #(
    .CHANNELS(4), .SYNC_STAGES(2), .DEBOUNCE_CYC(4),
    .REPEAT_EN(1), .REPEAT_DELAY(10), .REPEAT_PERIOD(3)
  ) dut (
    .clk(clk), .rst(rst), .btn_in(btn),
    .pulse(pulse), .rel_pulse(rel_pulse), .level(level)
  );

  pb_pulser_multi #(
    .CHANNELS(4), .SYNC_STAGES(2), .DEBOUNCE_CYC(4),
    .REPEAT_EN(0), .REPEAT_DELAY(10), .REPEAT_PERIOD(3)
  ) dut_norep (
    .clk(clk), .rst(rst), .btn_in(btn),
    .pulse(pulse_n), .rel_pulse(rel_pulse_n), .level(level_n)
  );

  typedef struct packed {
    logic [3:0] btn;
    logic [7:0] n;
    logic [3:0] p;
    logic [3:0] r;
    logic [3:0] l;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input logic [3:0] b, input int n,
                              input logic [3:0] p, input logic [3:0] r, input logic [3:0] l);
    vec_t v;
    v.btn = b;
    v.n   = 8'(n);
    v.p   = p;
    v.r   = r;
    v.l   = l;
    return v;
  endfunction

  task automatic chk(input string nm, input int row, input logic [3:0] act, input logic [3:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s row %0d: got %b, expected %b", nm, row, act, exp);
    end
  endtask

  task automatic chk_main(input string nm, input int row,
                          input logic [3:0] ep, input logic [3:0] er, input logic [3:0] el);
    chk({nm, ".pulse"}, row, pulse, ep);
    chk({nm, ".rel_pulse"}, row, rel_pulse, er);
    chk({nm, ".level"}, row, level, el);
  endtask

  task automatic chk_norep(input string nm, input int row,
                           input logic [3:0] ep, input logic [3:0] er, input logic [3:0] el);
    chk({nm, ".norep_pulse"}, row, pulse_n, ep);
    chk({nm, ".norep_rel"}, row, rel_pulse_n, er);
    chk({nm, ".norep_level"}, row, level_n, el);
  endtask

  function automatic bit in_list(input int v, input int lst[$]);
    foreach (lst[i]) begin
      if (lst[i] == v) return 1'b1;
    end
    return 1'b0;
  endfunction

  // Watchdog so the run always ends even if the sequencing stalls.
  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int row;
    int offs3[$];
    int offs4[$];
    logic [3:0] ep, er, el;

    // Clean press on ch0: pulse row 6, release first sampled at row 13, rel at row 19.
    tbl.push_back(mk(4'b0001, 6, 4'b0000, 4'b0000, 4'b0000));
    tbl.push_back(mk(4'b0001, 1, 4'b0001, 4'b0000, 4'b0001));
    tbl.push_back(mk(4'b0001, 6, 4'b0000, 4'b0000, 4'b0001));
    tbl.push_back(mk(4'b0000, 6, 4'b0000, 4'b0000, 4'b0001));
    tbl.push_back(mk(4'b0000, 1, 4'b0000, 4'b0001, 4'b0000));
    tbl.push_back(mk(4'b0000, 3, 4'b0000, 4'b0000, 4'b0000));
    // Bounce on ch1 (1,0,1,0) then stable from row 4: pulse row 10.
    tbl.push_back(mk(4'b0010, 1, 4'b0000, 4'b0000, 4'b0000));
    tbl.push_back(mk(4'b0000, 1, 4'b0000, 4'b0000, 4'b0000));
    tbl.push_back(mk(4'b0010, 1, 4'b0000, 4'b0000, 4'b0000));
    tbl.push_back(mk(4'b0000, 1, 4'b0000, 4'b0000, 4'b0000));
    tbl.push_back(mk(4'b0010, 6, 4'b0000, 4'b0000, 4'b0000));
    tbl.push_back(mk(4'b0010, 1, 4'b0010, 4'b0000, 4'b0010));
    tbl.push_back(mk(4'b0010, 2, 4'b0000, 4'b0000, 4'b0010));
    tbl.push_back(mk(4'b0000, 6, 4'b0000, 4'b0000, 4'b0010));
    tbl.push_back(mk(4'b0000, 1, 4'b0000, 4'b0010, 4'b0000));
    tbl.push_back(mk(4'b0000, 3, 4'b0000, 4'b0000, 4'b0000));
    // Simultaneous press on all channels, released at row 9.
    tbl.push_back(mk(4'b1111, 6, 4'b0000, 4'b0000, 4'b0000));
    tbl.push_back(mk(4'b1111, 1, 4'b1111, 4'b0000, 4'b1111));
    tbl.push_back(mk(4'b1111, 2, 4'b0000, 4'b0000, 4'b1111));
    tbl.push_back(mk(4'b0000, 6, 4'b0000, 4'b0000, 4'b1111));
    tbl.push_back(mk(4'b0000, 1, 4'b0000, 4'b1111, 4'b0000));
    tbl.push_back(mk(4'b0000, 3, 4'b0000, 4'b0000, 4'b0000));

    offs3 = '{0, 10, 13, 16, 19, 22, 25, 28};
    offs4 = '{0, 12, 15, 18, 21, 24};

    // Reset state.
    rst = 1'b1;
    btn = 4'b0000;
    repeat (3) @(negedge clk);
    chk_main("reset", 0, 4'b0000, 4'b0000, 4'b0000);
    chk_norep("reset", 0, 4'b0000, 4'b0000, 4'b0000);
    rst = 1'b0;

    // Table-driven scenarios; repeat never triggers in them so both instances agree.
    row = 0;
    foreach (tbl[i]) begin
      for (int k = 0; k < int'(tbl[i].n); k++) begin
        btn = tbl[i].btn;
        @(negedge clk);
        chk_main("tbl", row, tbl[i].p, tbl[i].r, tbl[i].l);
        chk_norep("tbl", row, tbl[i].p, tbl[i].r, tbl[i].l);
        row++;
      end
    end

    // Long hold on ch2: repeat schedule, release first sampled at row 34.
    for (int r = 0; r < 46; r++) begin
      btn = (r < 34) ? 4'b0100 : 4'b0000;
      @(negedge clk);
      ep = in_list(r - 6, offs3) ? 4'b0100 : 4'b0000;
      er = (r == 40) ? 4'b0100 : 4'b0000;
      el = (r >= 6 && r < 40) ? 4'b0100 : 4'b0000;
      chk_main("hold_ch2", r, ep, er, el);
      chk_norep("hold_ch2", r, (r == 6) ? 4'b0100 : 4'b0000, er, el);
    end

    // Release glitch on ch3 (rows 8,9 low): repeats shifted by two cycles.
    for (int r = 0; r < 40; r++) begin
      btn = (r < 8 || (r >= 10 && r < 29)) ? 4'b1000 : 4'b0000;
      @(negedge clk);
      ep = in_list(r - 6, offs4) ? 4'b1000 : 4'b0000;
      er = (r == 35) ? 4'b1000 : 4'b0000;
      el = (r >= 6 && r < 35) ? 4'b1000 : 4'b0000;
      chk_main("glitch_ch3", r, ep, er, el);
      chk_norep("glitch_ch3", r, (r == 6) ? 4'b1000 : 4'b0000, er, el);
    end

    // Reset during press debounce on ch0 with the button held.
    btn = 4'b0001;
    for (int r = 0; r < 3; r++) begin
      @(negedge clk);
      chk_main("rst_pre", r, 4'b0000, 4'b0000, 4'b0000);
    end
    rst = 1'b1;
    #1;
    chk_main("rst_db", 0, 4'b0000, 4'b0000, 4'b0000);
    @(negedge clk);
    @(negedge clk);
    chk_main("rst_db_hold", 0, 4'b0000, 4'b0000, 4'b0000);
    rst = 1'b0;
    for (int r = 0; r < 7; r++) begin
      @(negedge clk);
      ep = (r == 6) ? 4'b0001 : 4'b0000;
      chk_main("rst_db_after", r, ep, 4'b0000, ep);
    end

    // Reset in HELD during the press pulse: pulse and level drop at once.
    rst = 1'b1;
    #1;
    chk_main("rst_held", 0, 4'b0000, 4'b0000, 4'b0000);
    chk_norep("rst_held", 0, 4'b0000, 4'b0000, 4'b0000);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    for (int r = 0; r < 9; r++) begin
      @(negedge clk);
      ep = (r == 6) ? 4'b0001 : 4'b0000;
      el = (r >= 6) ? 4'b0001 : 4'b0000;
      chk_main("rst_held_after", r, ep, 4'b0000, el);
    end
    btn = 4'b0000;
    for (int r = 0; r < 10; r++) begin
      @(negedge clk);
      er = (r == 6) ? 4'b0001 : 4'b0000;
      el = (r < 6) ? 4'b0001 : 4'b0000;
      chk_main("rst_final_rel", r, 4'b0000, er, el);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/pb_pulser_multi.md
# pb_pulser_multi

Multi-channel push-button conditioner: each channel synchronises a raw asynchronous button input, debounces press and release, and emits a single-cycle `pulse` per press. A hold produces optional auto-repeat pulses. A separate single-cycle `rel_pulse` is emitted per release. The block sits between the board button pins and every module that consumes one-shot clock-enable or step strobes, and is the parametrised successor to the single-channel one-shot pulser.

## Interface
- `CHANNELS`, default 4: number of independent button channels (1..16).
- `SYNC_STAGES`, default 2: synchroniser flop count per channel (≥2).
- `DEBOUNCE_CYC`, default 50000: cycles the synchronised input must be stable to accept a press or release (≥1).
- `REPEAT_EN`, default 1: 1 enables auto-repeat while held; 0 gives exactly one pulse per press.
- `REPEAT_DELAY`, default 25000000: cycles from the press pulse to the first repeat pulse (≥2).
- `REPEAT_PERIOD`, default 5000000: cycles between subsequent repeat pulses (≥2).
- `clk` input 1: system clock.
- `rst` input 1: asynchronous, active-high reset.
- `btn_in` input `CHANNELS`: raw button levels, asynchronous, active-high.
- `pulse` output `CHANNELS`: single-cycle strobe on accepted press and on each repeat.
- `rel_pulse` output `CHANNELS`: single-cycle strobe on accepted release.
- `level` output `CHANNELS`: debounced button level.

## Operation
- Channels are fully independent. There is no arbitration, and simultaneous events on several channels all produce their strobes in the same cycle.
- Per-channel state machine has 4 states: IDLE, DB_PRESS, HELD, DB_REL. `s` denotes the synchronised input.
- IDLE:
  - `level`=0.
  - `s`=1 → DB_PRESS, debounce counter cleared.
- DB_PRESS:
  - `s`=0 → IDLE, with no output.
  - When `s` has been 1 for DEBOUNCE_CYC consecutive cycles → HELD. `pulse`=1 for one cycle, `level`=1, repeat counter cleared.
- HELD:
  - `level`=1.
  - `s`=0 → DB_REL, debounce counter cleared.
  - If REPEAT_EN, the repeat counter runs. `pulse`=1 for one cycle REPEAT_DELAY cycles after the press pulse, then every REPEAT_PERIOD cycles.
- DB_REL:
  - `level` stays 1. The repeat counter is frozen and no repeat pulses are issued.
  - `s`=1 → HELD, with no strobe. The repeat counter resumes from its frozen value.
  - When `s` has been 0 for DEBOUNCE_CYC consecutive cycles → IDLE. `rel_pulse`=1 for one cycle, `level`=0.
- Counter widths are `$clog2` of the largest count + 1. Counters saturate rather than wrap and never overflow.
- `pulse` and `rel_pulse` are never high for two consecutive cycles. On one channel they are never high in the same cycle.

## Timing
- All outputs are registered. Reset values: `pulse`=0, `rel_pulse`=0, `level`=0, all synchronisers 0, all channels in IDLE.
- Press latency: `btn_in` rises stably, sampled first at edge 0. `pulse` is high during the cycle after edge SYNC_STAGES+DEBOUNCE_CYC. Release latency is identical for `rel_pulse`.
- A glitch, or bounce, shorter than DEBOUNCE_CYC synchronised cycles produces no output.
- Repeat: the k-th repeat pulse (k≥1) occurs REPEAT_DELAY+(k−1)·REPEAT_PERIOD cycles after the press pulse, plus any cycles spent in DB_REL.
- Reset mid-operation:
  - Any in-flight pulse is dropped immediately.
  - A button still held at reset release is treated as a new press and gets the full sync+debounce latency.

## Structure
- Package `pb_pulser_pkg`:
  - State enum typedef `pb_state_t` (IDLE, DB_PRESS, HELD, DB_REL).
  - Counter-width helper function.
- Sub-module `pb_pulser_chan`: one channel, containing the synchroniser, FSM and both counters. It is instantiated CHANNELS times in a generate loop.
- The top level contains only the generate loop and port bit-slicing.

## Test plan
Parameters for all scenarios: CHANNELS=4, SYNC_STAGES=2, DEBOUNCE_CYC=4, REPEAT_DELAY=10, REPEAT_PERIOD=3.
- Clean press on ch0, held 8 cycles, then released:
  - `pulse[0]` high exactly in the cycle after edge 6.
  - `level[0]` rises with it.
  - `rel_pulse[0]` fires 6 cycles after the release edge.
  - No other channel toggles.
- Bounce: ch1 toggles 1,0,1,0 each cycle, then holds 1:
  - No strobe during bouncing.
  - Exactly one `pulse[1]` 6 cycles after the final stable rise.
- Hold ch2 for 30 cycles after acceptance:
  - Pulses at offsets 0, 10, 13, 16, 19, 22, 25, 28.
  - With REPEAT_EN=0, only offset 0 pulses.
- Release glitch: ch3 held, dropped for 2 cycles, then held again:
  - No `rel_pulse`, `level[3]` stays 1.
  - Repeat schedule is shifted by exactly the cycles spent in DB_REL.
- Simultaneous press on all 4 channels in the same cycle:
  - All `pulse` bits high in the same single cycle.
- `rst` asserted mid-debounce and mid-HELD on ch0 with `btn_in[0]` held high:
  - All outputs go to 0 immediately.
  - After `rst` release, `pulse[0]` occurs 6 cycles later.
